// File: rtl/bm_rng_sched.sv
// Sequencing and sharing controller for the Box-Muller Gaussian RNG core.
// Handles reseed and warm-up, drops early samples, buffers pairs and hands them out round-robin.
module bm_rng_sched #(
    parameter int NUM_REQ    = 4,
    parameter int DEPTH      = 8,
    parameter int RST_CYCLES = 2,
    parameter int DISCARD    = 4,
    parameter int TIMEOUT    = 63
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [191:0]               seed_in,
    input  logic                       reseed,
    output logic [191:0]               seed_out,
    output logic                       core_rst,
    input  logic                       core_valid,
    input  logic [15:0]                core_x0,
    input  logic [15:0]                core_x1,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [31:0]                gnt_data,
    output logic                       running,
    output logic                       err_timeout,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                drop_cnt,
    output logic [2:0]                 dbg_state
);

    // Handshake: req is a level held by the requester until it sees its gnt bit;
    // gnt is a one-cycle pulse carrying the popped FIFO head on gnt_data.

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [15:0]   RST_LAST  = 16'(RST_CYCLES - 1);
    localparam logic [15:0]   TO_LAST   = 16'(TIMEOUT - 1);
    localparam logic [15:0]   DISC_LAST = (DISCARD > 0) ? 16'(DISCARD - 1) : 16'd0;
    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
    localparam logic [PW:0]   NREQ      = (PW + 1)'(NUM_REQ);
    localparam logic [PW-1:0] LAST_REQ  = PW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        ST_RESEED  = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_DISCARD = 3'd2,
        ST_RUN     = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [15:0]     cnt;
    logic [15:0]     cnt_nxt;

    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [PW-1:0]   rr_ptr;

    logic            arb_hit;
    logic [PW-1:0]   arb_win;
    logic [PW:0]     idx;
    logic [PW-1:0]   rr_nxt;
    logic [NUM_REQ-1:0] gnt_vec;

    logic            do_pop;
    logic            do_push;
    logic            do_drop;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RESEED;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_nxt = state;
        if (reseed) begin
            state_nxt = ST_RESEED;
        end else begin
            case (state)
                ST_RESEED: begin
                    if (cnt == RST_LAST) state_nxt = ST_WARMUP;
                end
                ST_WARMUP: begin
                    if (core_valid) begin
                        state_nxt = (DISCARD == 0) ? ST_RUN : ST_DISCARD;
                    end else if (cnt == TO_LAST) begin
                        state_nxt = ST_ERROR;
                    end
                end
                ST_DISCARD: begin
                    if (core_valid && cnt == DISC_LAST) state_nxt = ST_RUN;
                end
                ST_RUN:   state_nxt = ST_RUN;
                ST_ERROR: state_nxt = ST_ERROR;
                default:  state_nxt = ST_RESEED;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        core_rst = 1'b0;
        running  = 1'b0;
        case (state)
            ST_RESEED: core_rst = 1'b1;
            ST_RUN:    running  = 1'b1;
            default:   ;
        endcase
    end

    assign dbg_state = state;

    // One counter serves every phase: it restarts on each state change.
    always_comb begin
        cnt_nxt = cnt;
        if (reseed || state_nxt != state) begin
            cnt_nxt = 16'd0;
        end else begin
            case (state)
                ST_RESEED, ST_WARMUP: cnt_nxt = cnt + 16'd1;
                ST_DISCARD:           if (core_valid) cnt_nxt = cnt + 16'd1;
                default:              cnt_nxt = cnt;
            endcase
        end
    end

    // Round-robin search starting at rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        arb_hit = 1'b0;
        arb_win = '0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, rr_ptr} + (PW + 1)'(i);
            if (idx >= NREQ) idx = idx - NREQ;
            if (!arb_hit && req[idx[PW-1:0]]) begin
                arb_hit = 1'b1;
                arb_win = idx[PW-1:0];
            end
        end
    end

    assign rr_nxt  = (arb_win == LAST_REQ) ? '0 : arb_win + PW'(1);
    assign gnt_vec = NUM_REQ'(1) << arb_win;

    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign do_pop  = (state == ST_RUN) && !reseed && (level != '0) && arb_hit;
    assign do_push = (state == ST_RUN) && !reseed && core_valid &&
                     ((level != FULL_LVL) || do_pop);
    assign do_drop = (state == ST_RUN) && !reseed && core_valid && !do_push;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seed_out    <= '0;
            cnt         <= 16'd0;
            gnt         <= '0;
            gnt_data    <= 32'd0;
            err_timeout <= 1'b0;
            level       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rr_ptr      <= '0;
            drop_cnt    <= 16'd0;
        end else begin
            cnt <= cnt_nxt;
            if (reseed) begin
                seed_out    <= seed_in;
                gnt         <= '0;
                err_timeout <= 1'b0;
                level       <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
            end else begin
                if (state == ST_WARMUP && state_nxt == ST_ERROR) err_timeout <= 1'b1;
                gnt <= do_pop ? gnt_vec : '0;
                if (do_pop) begin
                    gnt_data <= mem[rd_ptr];
                    rd_ptr   <= rd_ptr + AW'(1);
                    rr_ptr   <= rr_nxt;
                end
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                case ({do_push, do_pop})
                    2'b10:   level <= level + LW'(1);
                    2'b01:   level <= level - LW'(1);
                    default: level <= level;
                endcase
                if (do_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {core_x1, core_x0};
    end

endmodule
